// File: rtl/uhci_axi_pkg.sv
// Shared definitions for the AXI4-Lite to UHCI schedule/TD RAM bridge:
// response codes, bridge FSM states and the DWord one-hot decode.
package uhci_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned DWORDS_PER_ROW = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MEM,
    ST_WR_RESP,
    ST_RD_MEM,
    ST_RD_CAP,
    ST_RD_RESP
  } state_e;

  function automatic logic [DWORDS_PER_ROW-1:0] dword_onehot(input logic [1:0] sel);
    logic [DWORDS_PER_ROW-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/axi_mem_addr_dec.sv
// Combinational AXI byte address -> RAM row, one-hot DWord select and range flag.
module axi_mem_addr_dec
  import uhci_axi_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int NUM_COL        = 4
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [MEM_ADDR_WIDTH-1:0] row,
  output logic [NUM_COL-1:0]        col,
  output logic                      in_range
);

  // Byte lane bits are ignored: every access is aligned down to its DWord.
  logic lsb_unused;

  assign lsb_unused = ^addr[1:0];
  assign row        = addr[MEM_ADDR_WIDTH+3:4];
  assign col        = NUM_COL'(dword_onehot(addr[3:2]));
  assign in_range   = (addr >> (MEM_ADDR_WIDTH + 4)) == '0;

endmodule

// File: rtl/axi_lite_mem_bridge.sv
// AXI4-Lite slave turning each single-beat read/write into one one-cycle
// port-B access of the shared UHCI schedule/TD RAM.
module axi_lite_mem_bridge
  import uhci_axi_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int NUM_COL        = 4,
  parameter int COL_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [COL_WIDTH-1:0]      s_wdata,
  input  logic [COL_WIDTH/8-1:0]    s_wstrb,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [COL_WIDTH-1:0]      s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic                      mem_en,
  output logic [NUM_COL-1:0]        mem_w,
  output logic [NUM_COL-1:0]        mem_r,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [COL_WIDTH-1:0]      mem_din,
  input  logic [COL_WIDTH-1:0]      mem_dout
);

  state_e                    state_q, state_d;
  logic                      awr_q, awr_d;
  logic                      arr_q, arr_d;
  logic                      last_rd_q, last_rd_d;
  logic [MEM_ADDR_WIDTH-1:0] row_q, row_d;
  logic [NUM_COL-1:0]        col_q, col_d;
  logic                      ok_q, ok_d;
  logic [COL_WIDTH-1:0]      din_q, din_d;
  logic [1:0]                resp_q, resp_d;
  logic [COL_WIDTH-1:0]      rdata_q, rdata_d;

  logic [AXI_ADDR_WIDTH-1:0] dec_addr;
  logic [MEM_ADDR_WIDTH-1:0] dec_row;
  logic [NUM_COL-1:0]        dec_col;
  logic                      dec_in_range;

  // One decoder serves both channels; only the granted channel is ever latched.
  assign dec_addr = arr_q ? s_araddr : s_awaddr;

  axi_mem_addr_dec #(
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH),
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .NUM_COL       (NUM_COL)
  ) u_dec (
    .addr    (dec_addr),
    .row     (dec_row),
    .col     (dec_col),
    .in_range(dec_in_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      awr_q     <= 1'b0;
      arr_q     <= 1'b0;
      last_rd_q <= 1'b1;
      row_q     <= '0;
      col_q     <= '0;
      ok_q      <= 1'b0;
      din_q     <= '0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awr_q     <= awr_d;
      arr_q     <= arr_d;
      last_rd_q <= last_rd_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ok_q      <= ok_d;
      din_q     <= din_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awr_d     = 1'b0;
    arr_d     = 1'b0;
    last_rd_d = last_rd_q;
    row_d     = row_q;
    col_d     = col_q;
    ok_d      = ok_q;
    din_d     = din_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        // Ready is a registered one-cycle pulse; the grant is decided the
        // cycle before it, which is when the alternation flag flips.
        if (awr_q) begin
          if (s_awvalid && s_wvalid) begin
            row_d   = dec_row;
            col_d   = dec_col;
            ok_d    = dec_in_range && (&s_wstrb);
            resp_d  = (dec_in_range && (&s_wstrb)) ? RESP_OKAY : RESP_SLVERR;
            din_d   = s_wdata;
            state_d = ST_WR_MEM;
          end
        end else if (arr_q) begin
          if (s_arvalid) begin
            row_d   = dec_row;
            col_d   = dec_col;
            ok_d    = dec_in_range;
            resp_d  = dec_in_range ? RESP_OKAY : RESP_SLVERR;
            state_d = ST_RD_MEM;
          end
        end else if (s_awvalid && s_wvalid && (last_rd_q || !s_arvalid)) begin
          awr_d     = 1'b1;
          last_rd_d = 1'b0;
        end else if (s_arvalid) begin
          arr_d     = 1'b1;
          last_rd_d = 1'b1;
        end
      end
      ST_WR_MEM:  state_d = ST_WR_RESP;
      ST_WR_RESP: if (s_bready) state_d = ST_IDLE;
      ST_RD_MEM:  state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        rdata_d = ok_q ? mem_dout : '0;
        state_d = ST_RD_RESP;
      end
      ST_RD_RESP: if (s_rready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign s_awready = awr_q;
  assign s_wready  = awr_q;
  assign s_arready = arr_q;

  assign s_bvalid = (state_q == ST_WR_RESP);
  assign s_bresp  = s_bvalid ? resp_q : '0;
  assign s_rvalid = (state_q == ST_RD_RESP);
  assign s_rresp  = s_rvalid ? resp_q : '0;
  assign s_rdata  = rdata_q;

  assign mem_en   = ok_q && ((state_q == ST_WR_MEM) || (state_q == ST_RD_MEM));
  assign mem_w    = (ok_q && (state_q == ST_WR_MEM)) ? col_q : '0;
  assign mem_r    = (ok_q && (state_q == ST_RD_MEM)) ? col_q : '0;
  assign mem_addr = mem_en ? row_q : '0;
  assign mem_din  = (ok_q && (state_q == ST_WR_MEM)) ? din_q : '0;

endmodule

// File: tb/tb_axi_lite_mem_bridge.sv
// Scoreboard bench for axi_lite_mem_bridge: drivers push expectations from a
// flat DWord reference memory; a monitor checks port B and the B/R channels.
module tb_axi_lite_mem_bridge;

  localparam int MAW = 6;
  localparam int AAW = 12;
  localparam int NC  = 4;
  localparam int CW  = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [AAW-1:0] s_awaddr, s_araddr;
  logic           s_awvalid, s_awready, s_wvalid, s_wready, s_arvalid, s_arready;
  logic [CW-1:0]  s_wdata, s_rdata;
  logic [3:0]     s_wstrb;
  logic [1:0]     s_bresp, s_rresp;
  logic           s_bvalid, s_bready, s_rvalid, s_rready;
  logic           mem_en;
  logic [NC-1:0]  mem_w, mem_r;
  logic [MAW-1:0] mem_addr;
  logic [CW-1:0]  mem_din, mem_dout;

  always #5 clk = ~clk;

  axi_lite_mem_bridge #(
    .MEM_ADDR_WIDTH(MAW),
    .AXI_ADDR_WIDTH(AAW),
    .NUM_COL       (NC),
    .COL_WIDTH     (CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_en(mem_en), .mem_w(mem_w), .mem_r(mem_r), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  typedef struct {
    int          t;
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    int          t;
    logic        wr;
    logic [5:0]  row;
    logic [3:0]  col;
    logic [31:0] din;
  } macc_t;

  rsp_t        b_q[$];
  rsp_t        r_q[$];
  macc_t       m_q[$];
  logic [31:0] ref_mem [0:255];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          abort_mode = 1'b0;
  int          hold_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Physical RAM behind port B: dout is registered, valid the cycle after mem_r.
  logic [31:0] ram [0:63][0:3];
  initial begin
    for (int i = 0; i < 256; i++) ram[i/4][i%4] = seed_word(i);
    forever begin
      @(posedge clk);
      if (mem_en) begin
        for (int c = 0; c < 4; c++) begin
          if (mem_w[c]) ram[mem_addr][c] <= mem_din;
          if (mem_r[c]) mem_dout <= ram[mem_addr][c];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string why);
    checks++;
    failures++;
    $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, s_rresp,
               s_rdata, mem_en, mem_w, mem_r, mem_addr, mem_din}, '0);
  endtask

  // Reference model: flat array of 256 DWords indexed by byte address / 4.
  task automatic accept_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int t);
    rsp_t  r;
    macc_t m;
    bit    ok;
    ok     = (a < 12'd1024) && (s == 4'hF);
    r.t    = t + 2;
    r.resp = ok ? 2'b00 : 2'b10;
    r.data = '0;
    b_q.push_back(r);
    if (ok) begin
      ref_mem[a[9:2]] = d;
      m.t = t + 1; m.wr = 1'b1; m.row = a[9:4]; m.col = 4'b0001 << a[3:2]; m.din = d;
      m_q.push_back(m);
    end
  endtask

  task automatic accept_read(input logic [11:0] a, input int t);
    rsp_t  r;
    macc_t m;
    bit    ok;
    ok     = a < 12'd1024;
    r.t    = t + 3;
    r.resp = ok ? 2'b00 : 2'b10;
    r.data = ok ? ref_mem[a[9:2]] : 32'h0;
    r_q.push_back(r);
    if (ok) begin
      m.t = t + 1; m.wr = 1'b0; m.row = a[9:4]; m.col = 4'b0001 << a[3:2]; m.din = '0;
      m_q.push_back(m);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int t_acc);
    bit done = 1'b0;
    t_acc = -1;
    @(negedge clk);
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (s_awready && s_wready) begin
        done  = 1'b1;
        t_acc = cyc;
        if (!abort_mode) accept_write(a, d, s, cyc);
      end
    end
    if (!done) fail("aw_timeout", "write never accepted");
    @(posedge clk);
    #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output int t_acc);
    bit done = 1'b0;
    t_acc = -1;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (s_arready) begin
        done  = 1'b1;
        t_acc = cyc;
        accept_read(a, cyc);
      end
    end
    if (!done) fail("ar_timeout", "read never accepted");
    @(posedge clk);
    #1;
    s_arvalid = 1'b0;
  endtask

  task automatic pair(input logic [11:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                      input logic [11:0] ra, output int tw, output int tr);
    int a, b;
    fork
      do_write(wa, wd, ws, a);
      do_read(ra, b);
    join
    tw = a;
    tr = b;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && (b_q.size() + r_q.size() + m_q.size()) > 0; n++)
      @(negedge clk);
    if ((b_q.size() + r_q.size() + m_q.size()) > 0) begin
      fail("drain", "expected responses never arrived");
      b_q.delete(); r_q.delete(); m_q.delete();
    end
  endtask

  function automatic logic [11:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 12'($urandom_range(1024, 4095));
    return 12'($urandom_range(0, 1023));
  endfunction

  // Response-ready driver: random backpressure, or forced low after a hold request.
  initial begin
    int seen = 0;
    int cnt  = 0;
    s_bready = 1'b0;
    s_rready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (hold_req != seen) begin
        seen = hold_req;
        cnt  = 8;
      end
      if (cnt > 0) begin
        cnt--;
        s_bready = 1'b0;
        s_rready = 1'b0;
      end else begin
        s_bready = ($urandom_range(0, 3) != 0);
        s_rready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a port-B pulse or B/R beat.
  initial begin
    bit    bv_prev = 1'b0, rv_prev = 1'b0, en_prev = 1'b0;
    macc_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !abort_mode) begin
        if (mem_en) begin
          chk("mem_en_consecutive", en_prev, 1'b0);
          chk("mem_w_r_exclusive", (|mem_w) && (|mem_r), 1'b0);
          if (m_q.size() == 0) fail("mem_unexpected", "port-B access with none expected");
          else begin
            e = m_q.pop_front();
            chk("mem_latency", cyc, e.t);
            chk("mem_addr", mem_addr, e.row);
            chk("mem_w", mem_w, e.wr ? e.col : 4'b0);
            chk("mem_r", mem_r, e.wr ? 4'b0 : e.col);
            if (e.wr) chk("mem_din", mem_din, e.din);
          end
        end else if (m_q.size() > 0 && cyc > m_q[0].t) begin
          fail("mem_missing", "expected port-B access did not occur");
          void'(m_q.pop_front());
        end

        if (s_bvalid) begin
          if (b_q.size() == 0) fail("b_unexpected", "bvalid with no write outstanding");
          else begin
            if (!bv_prev) chk("b_latency", cyc, b_q[0].t);
            chk("bresp", s_bresp, b_q[0].resp);
            chk("no_accept_during_b", {s_awready, s_arready}, 2'b00);
            if (s_bready) void'(b_q.pop_front());
          end
        end else if (b_q.size() > 0 && cyc > b_q[0].t) begin
          fail("b_missing", "bvalid did not appear on time");
          void'(b_q.pop_front());
        end

        if (s_rvalid) begin
          if (r_q.size() == 0) fail("r_unexpected", "rvalid with no read outstanding");
          else begin
            if (!rv_prev) chk("r_latency", cyc, r_q[0].t);
            chk("rresp", s_rresp, r_q[0].resp);
            chk("rdata", s_rdata, r_q[0].data);
            chk("no_accept_during_r", {s_awready, s_arready}, 2'b00);
            if (s_rready) void'(r_q.pop_front());
          end
        end else if (r_q.size() > 0 && cyc > r_q[0].t) begin
          fail("r_missing", "rvalid did not appear on time");
          void'(r_q.pop_front());
        end
      end
      bv_prev = s_bvalid && !s_bready;
      rv_prev = s_rvalid && !s_rready;
      en_prev = mem_en;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          tw, tr, t;
    int          sel;
    logic [11:0] a, ra;
    logic [31:0] d;
    logic [3:0]  s;

    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    rst_n = 1'b0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    // Valids asserted during reset must not provoke any output.
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_write(12'h034, 32'hDEAD_BEEF, 4'hF, t);
    drain();
    do_read(12'h034, t);
    drain();

    // Last grant was a read, so a simultaneous pair goes write-first.
    pair(12'h1A8, 32'hCAFE_0001, 4'hF, 12'h034, tw, tr);
    chk("arb_write_first", tw < tr, 1'b1);
    drain();
    // After a lone write the next simultaneous pair goes read-first.
    do_write(12'h2C4, 32'h1357_9BDF, 4'hF, t);
    pair(12'h3F0, 32'h2468_ACE0, 4'hF, 12'h1A8, tw, tr);
    chk("arb_read_first", tr < tw, 1'b1);
    drain();

    do_write(12'h050, 32'hFFFF_0000, 4'h3, t);
    do_read(12'h400, t);
    do_write(12'h800, 32'h0BAD_F00D, 4'hF, t);
    do_read(12'h050, t);
    drain();

    hold_req++;
    do_write(12'h0C8, 32'hA5A5_5A5A, 4'hF, t);
    do_read(12'h0C8, t);
    drain();
    hold_req++;
    do_read(12'h2C4, t);
    drain();

    // Reset while the bridge is in its port-B write cycle.
    abort_mode = 1'b1;
    do_write(12'h0F0, 32'h7777_8888, 4'hF, t);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_en", mem_en, 1'b0);
    @(negedge clk);
    chk_zero("abort_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    abort_mode = 1'b0;
    @(negedge clk);
    do_read(12'h0F0, t);
    drain();
    do_write(12'h0F0, 32'h7777_8888, 4'hF, t);
    do_read(12'h0F0, t);
    drain();

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 3);
      a   = rand_addr();
      ra  = rand_addr();
      d   = $urandom;
      s   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 9) == 0) hold_req++;
      case (sel)
        0, 1:    do_write(a, d, s, t);
        2:       do_read(a, t);
        default: pair(a, d, s, ra, tw, tr);
      endcase
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
